// File: rtl/msp_requester.sv
// MSP v1 initiator: sends a `$M<` request frame on the TX byte stream, then parses
// the `$M>` / `$M!` reply from RX, streaming payload bytes and pulsing done with a status.
module msp_requester #(
  parameter int CLK_FREQ_HZ = 72_000_000,
  parameter int TIMEOUT_MS  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic [7:0] req_len,
  input  logic [7:0] req_pl_data,
  input  logic       req_pl_valid,
  output logic       req_pl_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_cmd,
  output logic [7:0] rsp_len,
  output logic       done,
  output logic [2:0] status,
  output logic       busy,
  output logic [3:0] dbg_state
);

  localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000 * TIMEOUT_MS;
  localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_ERR      = 3'd1;
  localparam logic [2:0] ST_CKSUM    = 3'd2;
  localparam logic [2:0] ST_TIMEOUT  = 3'd3;
  localparam logic [2:0] ST_MISMATCH = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_TX_HDR0, S_TX_HDR1, S_TX_HDR2, S_TX_LEN, S_TX_CMD, S_TX_PL, S_TX_CK,
    S_RX_SYNC, S_RX_M, S_RX_DIR, S_RX_LEN, S_RX_CMD, S_RX_PL, S_RX_CK, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d, len_q, len_d, cnt_q, cnt_d, ck_q, ck_d;
  logic [7:0]    rx_len_q, rx_len_d, rx_cmd_q, rx_cmd_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    tx_data_q, tx_data_d, rsp_data_q, rsp_data_d;
  logic          tx_valid_q, tx_valid_d, rsp_valid_q, rsp_valid_d, done_q, done_d;
  logic [2:0]    status_q, status_d;
  logic [7:0]    rsp_cmd_q, rsp_cmd_d, rsp_len_q, rsp_len_d;
  logic          tx_xfer, pl_xfer, in_pl, in_rx;

  // Handshakes are valid/ready: a byte moves on a cycle where both are high, and a
  // source with valid raised keeps its data stable until that cycle.
  assign in_pl        = (state_q == S_TX_PL) && !rst;
  assign tx_data      = in_pl ? req_pl_data : tx_data_q;
  assign tx_valid     = in_pl ? req_pl_valid : tx_valid_q;
  assign req_pl_ready = in_pl && tx_ready;
  assign req_ready    = (state_q == S_IDLE) && !rst;
  assign busy         = (state_q != S_IDLE) && !rst;
  assign rsp_data     = rsp_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_cmd      = rsp_cmd_q;
  assign rsp_len      = rsp_len_q;
  assign done         = done_q;
  assign status       = status_q;
  assign dbg_state    = state_q;

  assign tx_xfer = tx_valid_q && tx_ready;
  assign pl_xfer = req_pl_valid && tx_ready;
  assign in_rx   = (state_q == S_RX_SYNC) || (state_q == S_RX_M) || (state_q == S_RX_DIR) ||
                   (state_q == S_RX_LEN) || (state_q == S_RX_CMD) || (state_q == S_RX_PL) ||
                   (state_q == S_RX_CK);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    ck_d        = ck_q;
    rx_len_d    = rx_len_q;
    rx_cmd_d    = rx_cmd_q;
    err_d       = err_q;
    timer_d     = timer_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    done_d      = 1'b0;
    status_d    = status_q;
    rsp_cmd_d   = rsp_cmd_q;
    rsp_len_d   = rsp_len_q;

    case (state_q)
      S_IDLE: if (req_valid) begin
        cmd_d      = req_cmd;
        len_d      = req_len;
        ck_d       = 8'h00;
        err_d      = 1'b0;
        tx_valid_d = 1'b1;
        tx_data_d  = 8'h24;
        state_d    = S_TX_HDR0;
      end
      S_TX_HDR0: if (tx_xfer) begin tx_data_d = 8'h4D; state_d = S_TX_HDR1; end
      S_TX_HDR1: if (tx_xfer) begin tx_data_d = 8'h3C; state_d = S_TX_HDR2; end
      S_TX_HDR2: if (tx_xfer) begin tx_data_d = len_q; state_d = S_TX_LEN; end
      S_TX_LEN: if (tx_xfer) begin
        tx_data_d = cmd_q;
        ck_d      = ck_q ^ len_q;
        state_d   = S_TX_CMD;
      end
      S_TX_CMD: if (tx_xfer) begin
        ck_d  = ck_q ^ cmd_q;
        cnt_d = 8'h00;
        if (len_q == 8'h00) begin
          tx_data_d = ck_q ^ cmd_q;
          state_d   = S_TX_CK;
        end else begin
          tx_valid_d = 1'b0;
          state_d    = S_TX_PL;
        end
      end
      S_TX_PL: if (pl_xfer) begin
        ck_d  = ck_q ^ req_pl_data;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == len_q - 8'd1) begin
          tx_valid_d = 1'b1;
          tx_data_d  = ck_q ^ req_pl_data;
          state_d    = S_TX_CK;
        end
      end
      S_TX_CK: if (tx_xfer) begin
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        timer_d    = '0;
        state_d    = S_RX_SYNC;
      end
      S_RX_SYNC: if (rx_valid && rx_data == 8'h24) state_d = S_RX_M;
      S_RX_M: if (rx_valid) begin
        if (rx_data == 8'h4D)      state_d = S_RX_DIR;
        else if (rx_data != 8'h24) state_d = S_RX_SYNC;
      end
      S_RX_DIR: if (rx_valid) begin
        if (rx_data == 8'h3E) begin
          err_d   = 1'b0;
          state_d = S_RX_LEN;
        end else if (rx_data == 8'h21) begin
          err_d   = 1'b1;
          state_d = S_RX_LEN;
        end else if (rx_data == 8'h24) begin
          state_d = S_RX_M;
        end else begin
          state_d = S_RX_SYNC;
        end
      end
      S_RX_LEN: if (rx_valid) begin
        rx_len_d = rx_data;
        ck_d     = rx_data;
        state_d  = S_RX_CMD;
      end
      S_RX_CMD: if (rx_valid) begin
        rx_cmd_d = rx_data;
        ck_d     = ck_q ^ rx_data;
        cnt_d    = 8'h00;
        state_d  = (rx_len_q == 8'h00) ? S_RX_CK : S_RX_PL;
      end
      S_RX_PL: if (rx_valid) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = rx_data;
        ck_d        = ck_q ^ rx_data;
        cnt_d       = cnt_q + 8'd1;
        if (cnt_q == rx_len_q - 8'd1) state_d = S_RX_CK;
      end
      S_RX_CK: if (rx_valid) begin
        done_d    = 1'b1;
        rsp_cmd_d = rx_cmd_q;
        rsp_len_d = rx_len_q;
        if (rx_data != ck_q)     status_d = ST_CKSUM;
        else if (err_q)          status_d = ST_ERR;
        else if (rx_cmd_q != cmd_q) status_d = ST_MISMATCH;
        else                     status_d = ST_OK;
        state_d   = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A checksum byte landing on the expiry cycle still completes the frame.
    if (in_rx) begin
      timer_d = timer_q + 1'b1;
      if (timer_q == TO_LAST && !(state_q == S_RX_CK && rx_valid)) begin
        rsp_valid_d = 1'b0;
        done_d      = 1'b1;
        status_d    = ST_TIMEOUT;
        rsp_cmd_d   = 8'h00;
        rsp_len_d   = 8'h00;
        state_d     = S_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= 8'h00;
      len_q       <= 8'h00;
      cnt_q       <= 8'h00;
      ck_q        <= 8'h00;
      rx_len_q    <= 8'h00;
      rx_cmd_q    <= 8'h00;
      err_q       <= 1'b0;
      timer_q     <= '0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= ST_OK;
      rsp_cmd_q   <= 8'h00;
      rsp_len_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      ck_q        <= ck_d;
      rx_len_q    <= rx_len_d;
      rx_cmd_q    <= rx_cmd_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      done_q      <= done_d;
      status_q    <= status_d;
      rsp_cmd_q   <= rsp_cmd_d;
      rsp_len_q   <= rsp_len_d;
    end
  end

endmodule

// File: doc/msp_requester.md
# msp_requester

MSP v1 initiator: the flight-controller-side counterpart of `msp_handler`. It serializes a request frame (`$M<`, len, cmd, payload, checksum) onto a byte-stream TX port, then parses the `$M>` / `$M!` reply from a byte-stream RX port. Reply payload bytes are streamed to the consumer, and a one-cycle completion pulse carries a status code. It sits between a UART byte link and the control logic that polls or configures an MSP peer.

## Interface
- `CLK_FREQ_HZ`, 72_000_000: system clock frequency.
- `TIMEOUT_MS`, 100: reply timeout. `TIMEOUT_CYCLES = CLK_FREQ_HZ/1000*TIMEOUT_MS`; counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request strobe.
- `req_ready` out 1: high only in IDLE; low while `rst` is asserted.
- `req_cmd` in 8: MSP command; latched on acceptance.
- `req_len` in 8: request payload byte count; latched on acceptance.
- `req_pl_data` in 8: request payload byte.
- `req_pl_valid` in 1: payload byte valid.
- `req_pl_ready` out 1: payload byte consumed.
- `tx_data` out 8: byte to UART.
- `tx_valid` out 1: TX byte valid.
- `tx_ready` in 1: UART accepts the byte.
- `rx_data` in 8: byte from UART.
- `rx_valid` in 1: one-cycle RX strobe.
- `rsp_data` out 8: reply payload byte.
- `rsp_valid` out 1: one-cycle strobe per reply payload byte.
- `rsp_cmd` out 8: cmd field of the reply; valid when `done` is high.
- `rsp_len` out 8: len field of the reply; valid when `done` is high.
- `done` out 1: one-cycle completion pulse.
- `status` out 3: 0 OK, 1 ERR_REPLY, 2 CKSUM_ERR, 3 TIMEOUT, 4 CMD_MISMATCH. Valid when `done` is high, held until the next `done`.
- `busy` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, TX_HDR0, TX_HDR1, TX_HDR2, TX_LEN, TX_CMD, TX_PL, TX_CK, RX_SYNC, RX_M, RX_DIR, RX_LEN, RX_CMD, RX_PL, RX_CK, DONE.
- **Acceptance:** `req_valid && req_ready` latches cmd and len, and clears the running checksum.
- **TX sequence:**
  - Bytes sent in order: 0x24, 0x4D, 0x3C, len, cmd, payload, checksum.
  - A byte transfers on `tx_valid && tx_ready`; the FSM advances only on a transfer.
  - Checksum is the XOR of len, cmd and all payload bytes.
  - TX_PL is skipped when len = 0.
- **TX_PL pass-through (combinational):** `tx_data = req_pl_data`, `tx_valid = req_pl_valid`, `req_pl_ready = tx_ready`.
  - The byte counter and checksum update on each transfer.
  - `req_pl_ready` is 0 in all other states.
- **Other TX states:** `tx_data` and `tx_valid` are registered. `tx_data` is held stable while `tx_valid && !tx_ready`.
- **RX gating:** RX bytes are ignored in IDLE and all TX states.
- **RX_SYNC:** discards bytes until 0x24.
- **RX_M:**
  - 0x4D → RX_DIR.
  - 0x24 → stay in RX_M.
  - Any other byte → RX_SYNC.
- **RX_DIR:**
  - 0x3E (`>`) → RX_LEN.
  - 0x21 (`!`) → RX_LEN and sets the error flag.
  - Any other byte → RX_SYNC (0x24 → RX_M).
- **RX fields:** RX_LEN and RX_CMD capture the fields and seed the checksum.
- **RX_PL:** each byte is XORed into the checksum and emitted on `rsp_data`/`rsp_valid`. The consumer must discard the payload if the final status ≠ OK. RX_PL is skipped when len = 0.
- **RX_CK status, priority order:**
  1. Checksum mismatch → CKSUM_ERR.
  2. Else error flag set → ERR_REPLY.
  3. Else reply cmd ≠ request cmd → CMD_MISMATCH.
  4. Else OK.
- **Timeout:**
  - The counter clears on the TX checksum transfer and increments every cycle in RX states. It is not restarted by RX bytes.
  - On reaching `TIMEOUT_CYCLES`: DONE with status TIMEOUT, `rsp_cmd`/`rsp_len` = 0.
- **DONE:** asserts `done` for one cycle, then returns to IDLE.
- **Reset mid-operation:** returns to IDLE with no `done` pulse. A partial TX frame is abandoned.

## Timing
- **Reset values:** `tx_valid` 0, `tx_data` 0x00, `rsp_valid` 0, `rsp_data` 0x00, `done` 0, `status` 0, `rsp_cmd` 0, `rsp_len` 0, `busy` 0, `req_pl_ready` 0, `req_ready` 0 during `rst`.
- **TX latency:**
  - `tx_valid` (0x24) rises the cycle after acceptance.
  - With `tx_ready` held high, one byte transfers per cycle. A len = 0 frame completes 6 cycles after acceptance.
- **RX latency:**
  - `rsp_valid` is registered, one cycle after the payload byte's `rx_valid`.
  - `done` is high exactly one cycle after the checksum byte's `rx_valid`.
- **Timeout timing:** `done` rises `TIMEOUT_CYCLES`+1 cycles after the TX checksum transfer.
- **Tie-break:** if the checksum byte arrives on the expiry cycle, the frame wins.
- **Back-to-back requests:** `req_ready` re-asserts the cycle after `done`, so the minimum request-to-request spacing is 1 idle cycle.

## Test plan
- **MSP_IDENT round trip:**
  - Stimulus: cmd 0x64, len 0, `tx_ready`=1.
  - Required TX: 24 4D 3C 00 64 64.
  - Inject reply 24 4D 3E 07 64 01 00 00 00 00 00 00 62.
  - Required response: 7 `rsp_valid` strobes (first 0x01); `done` one cycle after 0x62 with status 0, `rsp_len` 7, `rsp_cmd` 0x64.
- **Payload with backpressure:**
  - Stimulus: cmd 0xD6, len 2, payload E8 03; `tx_ready` toggles every cycle.
  - Required TX: 24 4D 3C 02 D6 E8 03 3F, with no byte dropped or duplicated and `tx_data` stable while stalled.
- **Bad checksum:** the IDENT reply with a final byte of 0x00 → status 2.
- **Error reply after garbage:** prefix 00 FF 24 24, then 4D 21 00 64 64 → status 1; the garbage bytes produce no `rsp_valid`.
- **Timeout:**
  - Stimulus: `CLK_FREQ_HZ`=1_000_000, `TIMEOUT_MS`=1, no reply.
  - Required response: `done` with status 3 exactly 1001 cycles after the TX checksum transfer.
- **Reset during RX_PL:** assert `rst` → no `done`; `req_ready` returns to 1 the cycle after `rst` deasserts; the next IDENT request completes with status 0.
